writeback_stage_p: RTL and testbench
====================================

// Module: writeback_stage_p
// PURPOSE
//  Parametrised writeback stage: selects ALU, memory or link result, sign/zero-extends sub-word loads,
//  and holds the result in one output register with valid/ready flow control toward the register-file
//  write port. Also emits the register-file write strobe, a forwarding copy and a retired-instruction count.
//  Sits between the MEM/WB boundary and the register file of the pipelined processor.
// PARAMETERS
//  DATA_W            32  datapath width (multiple of 16, >= 16)
//  REG_ADDR_W        5   register-file address width
//  CNT_W             32  retired-instruction counter width
//  ZERO_REG_SUPPRESS 1   1: writes to register 0 never assert rf_we
// PORTS
//  clk          in   1           rising-edge clock
//  rst_n        in   1           synchronous active-low reset
//  in_valid     in   1           upstream result valid
//  in_ready     out  1           stage can accept (upstream handshake on in_valid && in_ready)
//  res_sel      in   2           00 ALU, 01 MEM, 10 LINK, 11 reserved (treated as ALU)
//  reg_write    in   1           instruction writes a register
//  write_reg    in   REG_ADDR_W  destination register
//  alu_out      in   DATA_W      ALU result; bits [1:0] are the load byte offset
//  read_data    in   DATA_W      raw memory word
//  pc_plus4     in   DATA_W      link value
//  ld_size      in   2           00 byte, 01 half, 10/11 word
//  ld_unsigned  in   1           1 zero-extend, 0 sign-extend
//  out_valid    out  1           output register holds a result
//  out_ready    in   1           register-file port accepts this cycle
//  rf_we        out  1           register-file write enable
//  rf_waddr     out  REG_ADDR_W  register-file write address
//  rf_wdata     out  DATA_W      register-file write data (= resultW)
//  fwd_valid    out  1           out_valid && reg_write_q && address non-zero (when suppressing)
//  fwd_addr     out  REG_ADDR_W  forwarding destination register
//  fwd_data     out  DATA_W      forwarding data
//  retire_count out  CNT_W       number of results retired
// BEHAVIOUR
//  - Reset (rst_n low at a clk edge): out_valid, rf_we, fwd_valid = 0; rf_waddr, rf_wdata, fwd_* = 0;
//    retire_count = 0. in_ready is forced to 0 while rst_n is low. A reset mid-stall discards the held result.
//  - Two states: EMPTY (out_valid=0) and FULL (out_valid=1). in_ready = EMPTY || out_ready (combinational).
//  - Accept: on in_valid && in_ready, the result is computed combinationally and registered.
//    Latency is 1 cycle from the accept edge to out_valid. State goes to / stays FULL.
//  - Retire: on out_valid && out_ready, the result leaves the stage. If there is no accept in the same
//    cycle, the state goes to EMPTY. Accept and retire in the same cycle = back-to-back: the register
//    reloads, the state stays FULL, no bubble.
//  - Stall: FULL && !out_ready keeps all output registers stable; in_ready = 0.
//  - rf_we = out_valid && out_ready && reg_write_q && !(ZERO_REG_SUPPRESS && rf_waddr==0) (combinational).
//  - retire_count increments by 1 on each retire (whether or not reg_write_q is set).
//    It wraps modulo 2^CNT_W without saturating.
//  - Result select: MEM uses the load-extension path; LINK = pc_plus4; ALU and reserved = alu_out.
//  - Load extension (MEM path, little-endian):
//    - byte: lane alu_out[1:0]
//    - half: lane alu_out[1]; alu_out[0] is ignored
//    - word: read_data unchanged
//    - Extension to DATA_W is by the MSB of the selected lane, or zeros when ld_unsigned=1.
// CONFIGURATION
//  WB_SUBWORD_EN defined: byte/half extension as above.
//  Not defined: ld_size and ld_unsigned are ignored, and MEM yields read_data unchanged (word-only loads).
//  Ports are identical in both builds.
// STRUCTURE
//  Shared package wb_pkg: res_sel encodings (RES_ALU, RES_MEM, RES_LINK) and ld_size encodings
//  (LD_BYTE, LD_HALF, LD_WORD).
//  One sub-module: load_extend (combinational lane select + extension; the identity when
//  WB_SUBWORD_EN is undefined).
//  Top level: the select mux, the output register/state, and the retire counter.
// TESTING
//  1. res_sel=00, alu_out=3, reg_write=1, write_reg=5, out_ready=1
//     -> next cycle: out_valid=1, rf_we=1, rf_waddr=5, rf_wdata=3; retire_count=1 after that edge.
//  2. res_sel=01, read_data=32'h8034_12F0, ld_size=00, alu_out[1:0]=0, ld_unsigned=0
//     -> rf_wdata=32'hFFFF_FFF0; with ld_unsigned=1 -> 32'h0000_00F0;
//     half with alu_out[1:0]=2 -> 32'hFFFF_8034 (without WB_SUBWORD_EN: 32'h8034_12F0).
//  3. write_reg=0, reg_write=1, alu_out=7 -> rf_we=0, fwd_valid=0, retire_count still increments.
//  4. Hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs stable;
//     release -> results retire back-to-back, one per cycle, none lost or duplicated.
//  5. res_sel=10, pc_plus4=32'h0040_0008 -> rf_wdata=32'h0040_0008; res_sel=11 -> alu_out.
//  6. Drop rst_n while FULL and stalled -> next edge: out_valid=0, retire_count=0, in_ready=0 during reset;
//     with CNT_W=4, 17 retires -> retire_count=1.

Source files
------------

// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - result-select and load-size encodings shared by the writeback stage
package wb_pkg;

  localparam logic [1:0] RES_ALU  = 2'b00;
  localparam logic [1:0] RES_MEM  = 2'b01;
  localparam logic [1:0] RES_LINK = 2'b10;

  localparam logic [1:0] LD_BYTE  = 2'b00;
  localparam logic [1:0] LD_HALF  = 2'b01;
  localparam logic [1:0] LD_WORD  = 2'b10;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } wb_state_e;

endpackage

// File: rtl/writeback_stage_p_load_extend.sv
// rtl/writeback_stage_p_load_extend.sv - little-endian lane select and sign/zero extension of loads
// Sub-word paths exist only with WB_SUBWORD_EN defined; otherwise the memory word passes through.
module load_extend
  import wb_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] read_data,
  input  logic [1:0]        byte_off,
  input  logic [1:0]        ld_size,
  input  logic              ld_unsigned,
  output logic [DATA_W-1:0] data_out
);

`ifdef WB_SUBWORD_EN
  // Widened to 32 bits so byte lanes 2/3 stay in range when DATA_W is 16.
  localparam int LANE_W = (DATA_W < 32) ? 32 : DATA_W;

  logic [LANE_W-1:0] w_word;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;

  assign w_word = LANE_W'(read_data);
  assign w_byte = w_word[{byte_off, 3'b000} +: 8];
  assign w_half = w_word[{byte_off[1], 4'b0000} +: 16];

  always_comb begin
    data_out = read_data;
    case (ld_size)
      LD_BYTE: begin
        data_out      = {DATA_W{w_byte[7] & ~ld_unsigned}};
        data_out[7:0] = w_byte;
      end
      LD_HALF: begin
        data_out       = {DATA_W{w_half[15] & ~ld_unsigned}};
        data_out[15:0] = w_half;
      end
      default: ;
    endcase
  end
`else
  logic w_unused;

  assign w_unused = ^{byte_off, ld_size, ld_unsigned};
  assign data_out = read_data;
`endif

endmodule

// File: rtl/writeback_stage_p.sv
// rtl/writeback_stage_p.sv - result select, one-entry valid/ready output register, retire counter
// Sub-word load extension is enabled by defining WB_SUBWORD_EN.
module writeback_stage_p
  import wb_pkg::*;
#(
  parameter int DATA_W            = 32,
  parameter int REG_ADDR_W        = 5,
  parameter int CNT_W             = 32,
  parameter int ZERO_REG_SUPPRESS = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            res_sel,
  input  logic                  reg_write,
  input  logic [REG_ADDR_W-1:0] write_reg,
  input  logic [DATA_W-1:0]     alu_out,
  input  logic [DATA_W-1:0]     read_data,
  input  logic [DATA_W-1:0]     pc_plus4,
  input  logic [1:0]            ld_size,
  input  logic                  ld_unsigned,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0]     rf_wdata,
  output logic                  fwd_valid,
  output logic [REG_ADDR_W-1:0] fwd_addr,
  output logic [DATA_W-1:0]     fwd_data,
  output logic [CNT_W-1:0]      retire_count
);

  wb_state_e             r_state;
  wb_state_e             w_state_nxt;
  logic [DATA_W-1:0]     r_data;
  logic [REG_ADDR_W-1:0] r_addr;
  logic                  r_reg_write;
  logic [CNT_W-1:0]      r_count;
  logic [DATA_W-1:0]     w_mem_data;
  logic [DATA_W-1:0]     w_result;
  logic                  w_accept;
  logic                  w_retire;
  logic                  w_addr_ok;

  load_extend #(.DATA_W(DATA_W)) u_load_extend (
    .read_data   (read_data),
    .byte_off    (alu_out[1:0]),
    .ld_size     (ld_size),
    .ld_unsigned (ld_unsigned),
    .data_out    (w_mem_data)
  );

  always_comb begin
    w_result = alu_out;
    case (res_sel)
      RES_MEM:  w_result = w_mem_data;
      RES_LINK: w_result = pc_plus4;
      default:  ;
    endcase
  end

  assign in_ready = rst_n && ((r_state == ST_EMPTY) || out_ready);
  assign w_accept = in_valid && in_ready;
  assign w_retire = (r_state == ST_FULL) && out_ready;

  // Accept wins over retire so a simultaneous pair keeps the stage FULL with no bubble.
  always_comb begin
    w_state_nxt = r_state;
    if (w_accept) begin
      w_state_nxt = ST_FULL;
    end else if (w_retire) begin
      w_state_nxt = ST_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_data      <= '0;
      r_addr      <= '0;
      r_reg_write <= 1'b0;
    end else if (w_accept) begin
      r_data      <= w_result;
      r_addr      <= write_reg;
      r_reg_write <= reg_write;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (w_retire) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign w_addr_ok    = (ZERO_REG_SUPPRESS == 0) || (r_addr != '0);
  assign out_valid    = (r_state == ST_FULL);
  assign rf_we        = out_valid && out_ready && r_reg_write && w_addr_ok;
  assign rf_waddr     = r_addr;
  assign rf_wdata     = r_data;
  assign fwd_valid    = out_valid && r_reg_write && w_addr_ok;
  assign fwd_addr     = r_addr;
  assign fwd_data     = r_data;
  assign retire_count = r_count;

endmodule

// File: tb/tb_writeback_stage_p.sv
// tb/tb_writeback_stage_p.sv - directed self-checking bench for writeback_stage_p (CNT_W=4)
module tb_writeback_stage_p;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  res_sel;
  logic        reg_write;
  logic [4:0]  write_reg;
  logic [31:0] alu_out;
  logic [31:0] read_data;
  logic [31:0] pc_plus4;
  logic [1:0]  ld_size;
  logic        ld_unsigned;
  logic        out_valid;
  logic        out_ready;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        fwd_valid;
  logic [4:0]  fwd_addr;
  logic [31:0] fwd_data;
  logic [3:0]  retire_count;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  writeback_stage_p #(
    .DATA_W(32), .REG_ADDR_W(5), .CNT_W(4), .ZERO_REG_SUPPRESS(1)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .res_sel(res_sel), .reg_write(reg_write), .write_reg(write_reg),
    .alu_out(alu_out), .read_data(read_data), .pc_plus4(pc_plus4),
    .ld_size(ld_size), .ld_unsigned(ld_unsigned), .out_valid(out_valid),
    .out_ready(out_ready), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .fwd_valid(fwd_valid), .fwd_addr(fwd_addr),
    .fwd_data(fwd_data), .retire_count(retire_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] sel, input logic [31:0] alu, input logic [31:0] rd,
                       input logic [31:0] pc, input logic [1:0] sz, input logic uns,
                       input logic rw, input logic [4:0] wr);
    res_sel     = sel;
    alu_out     = alu;
    read_data   = rd;
    pc_plus4    = pc;
    ld_size     = sz;
    ld_unsigned = uns;
    reg_write   = rw;
    write_reg   = wr;
    in_valid    = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    drive(2'b00, 32'h0, 32'h0, 32'h0, 2'b10, 1'b0, 1'b0, 5'd0);
    in_valid = 1'b0;
    step(); step();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (rf_we !== 1'b0 || fwd_valid !== 1'b0) begin errors++; $display("FAIL reset_we: rf_we=%b fwd_valid=%b want 0/0", rf_we, fwd_valid); end
    checks++; if (rf_wdata !== 32'h0 || rf_waddr !== 5'd0) begin errors++; $display("FAIL reset_data: got %h/%0d want 0/0", rf_wdata, rf_waddr); end
    checks++; if (retire_count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", retire_count); end
    rst_n = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b want 1", in_ready); end
    exp_cnt = 0;
  endtask

  task automatic test_alu();
    out_ready = 1'b1;
    drive(2'b00, 32'd3, 32'h0, 32'h0, 2'b10, 1'b0, 1'b1, 5'd5);
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || rf_we !== 1'b1) begin errors++; $display("FAIL alu_valid_we: out_valid=%b rf_we=%b want 1/1", out_valid, rf_we); end
    checks++; if (rf_waddr !== 5'd5 || rf_wdata !== 32'd3) begin errors++; $display("FAIL alu_data: got %0d/%h want 5/00000003", rf_waddr, rf_wdata); end
    checks++; if (fwd_valid !== 1'b1 || fwd_addr !== 5'd5 || fwd_data !== 32'd3) begin errors++; $display("FAIL alu_fwd: got %b/%0d/%h want 1/5/00000003", fwd_valid, fwd_addr, fwd_data); end
    checks++; if (retire_count !== 4'd0) begin errors++; $display("FAIL alu_count_before: got %0d want 0", retire_count); end
    step(); exp_cnt++;
    checks++; if (retire_count !== 4'd1 || out_valid !== 1'b0) begin errors++; $display("FAIL alu_retire: count=%0d out_valid=%b want 1/0", retire_count, out_valid); end
  endtask

  task automatic test_load();
    logic [31:0] t_alu [9] = '{32'd0, 32'd0, 32'd2, 32'd3, 32'd1, 32'd3, 32'd0, 32'd0, 32'd1};
    logic [1:0]  t_sz  [9] = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01, 2'b01, 2'b10, 2'b11};
    logic        t_uns [9] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
`ifdef WB_SUBWORD_EN
    logic [31:0] t_exp [9] = '{32'hFFFF_FFF0, 32'h0000_00F0, 32'hFFFF_8034, 32'hFFFF_FF80,
                               32'h0000_0012, 32'h0000_8034, 32'h0000_12F0, 32'h8034_12F0,
                               32'h8034_12F0};
`else
    logic [31:0] t_exp [9] = '{32'h8034_12F0, 32'h8034_12F0, 32'h8034_12F0, 32'h8034_12F0,
                               32'h8034_12F0, 32'h8034_12F0, 32'h8034_12F0, 32'h8034_12F0,
                               32'h8034_12F0};
`endif
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      drive(2'b01, t_alu[i], 32'h8034_12F0, 32'h0, t_sz[i], t_uns[i], 1'b1, 5'd7);
      step();
      in_valid = 1'b0;
      checks++;
      if (rf_wdata !== t_exp[i] || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL load_%0d: got %h valid=%b want %h valid=1", i, rf_wdata, out_valid, t_exp[i]);
      end
      step(); exp_cnt++;
    end
  endtask

  task automatic test_zero_reg();
    out_ready = 1'b1;
    drive(2'b00, 32'd7, 32'h0, 32'h0, 2'b10, 1'b0, 1'b1, 5'd0);
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || rf_we !== 1'b0 || fwd_valid !== 1'b0) begin errors++; $display("FAIL zero_reg_we: valid=%b rf_we=%b fwd=%b want 1/0/0", out_valid, rf_we, fwd_valid); end
    checks++; if (rf_wdata !== 32'd7) begin errors++; $display("FAIL zero_reg_data: got %h want 00000007", rf_wdata); end
    step(); exp_cnt++;
    checks++; if (retire_count !== 4'(exp_cnt)) begin errors++; $display("FAIL zero_reg_count: got %0d want %0d", retire_count, 4'(exp_cnt)); end
    drive(2'b00, 32'd9, 32'h0, 32'h0, 2'b10, 1'b0, 1'b0, 5'd9);
    step();
    in_valid = 1'b0;
    checks++; if (rf_we !== 1'b0 || fwd_valid !== 1'b0 || out_valid !== 1'b1) begin errors++; $display("FAIL no_write_we: rf_we=%b fwd=%b valid=%b want 0/0/1", rf_we, fwd_valid, out_valid); end
    step(); exp_cnt++;
    checks++; if (retire_count !== 4'(exp_cnt)) begin errors++; $display("FAIL no_write_count: got %0d want %0d", retire_count, 4'(exp_cnt)); end
  endtask

  task automatic test_link();
    out_ready = 1'b1;
    drive(2'b10, 32'h55, 32'h0, 32'h0040_0008, 2'b10, 1'b0, 1'b1, 5'd31);
    step();
    in_valid = 1'b0;
    checks++; if (rf_wdata !== 32'h0040_0008 || rf_waddr !== 5'd31) begin errors++; $display("FAIL link: got %h/%0d want 00400008/31", rf_wdata, rf_waddr); end
    step(); exp_cnt++;
    drive(2'b11, 32'h0000_ABCD, 32'h1111_1111, 32'h2222_2222, 2'b10, 1'b0, 1'b1, 5'd2);
    step();
    in_valid = 1'b0;
    checks++; if (rf_wdata !== 32'h0000_ABCD) begin errors++; $display("FAIL reserved_sel: got %h want 0000abcd", rf_wdata); end
    step(); exp_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] v [4] = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
    out_ready = 1'b0;
    drive(2'b00, v[0], 32'h0, 32'h0, 2'b10, 1'b0, 1'b1, 5'd1);
    step();
    drive(2'b00, v[1], 32'h0, 32'h0, 2'b10, 1'b0, 1'b1, 5'd2);
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || rf_wdata !== v[0] || rf_waddr !== 5'd1 || rf_we !== 1'b0) begin
        errors++;
        $display("FAIL stall_%0d: ready=%b valid=%b data=%h addr=%0d we=%b want 0/1/%h/1/0", c, in_ready, out_valid, rf_wdata, rf_waddr, rf_we, v[0]);
      end
      step();
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1 || rf_we !== 1'b1) begin errors++; $display("FAIL release_ready: ready=%b we=%b want 1/1", in_ready, rf_we); end
    for (int k = 1; k < 4; k++) begin
      drive(2'b00, v[k], 32'h0, 32'h0, 2'b10, 1'b0, 1'b1, 5'(k + 1));
      step(); exp_cnt++;
      checks++;
      if (out_valid !== 1'b1 || rf_wdata !== v[k] || rf_we !== 1'b1 || retire_count !== 4'(exp_cnt)) begin
        errors++;
        $display("FAIL b2b_%0d: valid=%b data=%h we=%b cnt=%0d want 1/%h/1/%0d", k, out_valid, rf_wdata, rf_we, retire_count, v[k], 4'(exp_cnt));
      end
    end
    in_valid = 1'b0;
    step(); exp_cnt++;
    checks++; if (out_valid !== 1'b0 || retire_count !== 4'(exp_cnt)) begin errors++; $display("FAIL b2b_drain: valid=%b cnt=%0d want 0/%0d", out_valid, retire_count, 4'(exp_cnt)); end
  endtask

  task automatic test_reset_mid_stall();
    out_ready = 1'b0;
    drive(2'b00, 32'h99, 32'h0, 32'h0, 2'b10, 1'b0, 1'b1, 5'd4);
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || retire_count === 4'd0) begin errors++; $display("FAIL pre_reset: valid=%b cnt=%0d want 1/nonzero", out_valid, retire_count); end
    rst_n = 1'b0; out_ready = 1'b1; in_valid = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_hold_ready: got %b want 0", in_ready); end
    step();
    checks++; if (out_valid !== 1'b0 || retire_count !== 4'd0 || rf_wdata !== 32'h0 || rf_we !== 1'b0) begin errors++; $display("FAIL mid_reset: valid=%b cnt=%0d data=%h we=%b want 0/0/0/0", out_valid, retire_count, rf_wdata, rf_we); end
    in_valid = 1'b0;
    rst_n = 1'b1;
    exp_cnt = 0;
  endtask

  task automatic test_wrap();
    out_ready = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      drive(2'b00, 32'(i), 32'h0, 32'h0, 2'b10, 1'b0, 1'b1, 5'd3);
      step();
    end
    checks++; if (retire_count !== 4'd0 || out_valid !== 1'b1) begin errors++; $display("FAIL wrap_16: cnt=%0d valid=%b want 0/1", retire_count, out_valid); end
    in_valid = 1'b0;
    step();
    checks++; if (retire_count !== 4'd1 || out_valid !== 1'b0) begin errors++; $display("FAIL wrap_17: cnt=%0d valid=%b want 1/0", retire_count, out_valid); end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_zero_reg();
    test_link();
    test_back_to_back();
    test_reset_mid_stall();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
